// File: rtl/vram_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vram_arb_pkg
//  Description : Shared types and default constants for the VRAM port-A
//                arbiter (arbiter mode, grant selector, parameter defaults).
//  Revision    : 1.0 - initial release
// ============================================================================
package vram_arb_pkg;

    // Arbiter operating mode.
    typedef enum logic [0:0] {
        CPU_PRIO  = 1'b0,
        CAM_DRAIN = 1'b1
    } arb_mode_e;

    // Owner of RAM port A in the current cycle.
    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_CPU  = 2'd1,
        GNT_CAM  = 2'd2
    } arb_grant_e;

    // Default parameter values.
    localparam int C_ADDR_W     = 16;
    localparam int C_DATA_W     = 32;
    localparam int C_FIFO_DEPTH = 8;
    localparam int C_HIGH_WATER = 6;
    localparam int C_LOW_WATER  = 2;
    localparam int C_MAX_WAIT   = 16;

endpackage
`default_nettype wire

// File: rtl/vram_wr_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : vram_wr_fifo
//  Description : Synchronous FIFO holding {address, data} camera pixel writes
//                bound for video RAM. Head entry is presented combinationally
//                (first-word fall-through).
//  Ports       : clk, reset (async, active-low)
//                i_push / i_addr / i_data : write side (ignored when full)
//                i_pop                    : consume head (ignored when empty)
//                o_head_addr / o_head_data: current head entry
//                o_level / o_full / o_empty: occupancy status
//  Revision    : 1.0 - initial release
// ============================================================================
module vram_wr_fifo #(
    parameter int AW    = 16,
    parameter int DW    = 32,
    parameter int DEPTH = 8     // power of 2, minimum 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic [AW-1:0]            i_addr,
    input  logic [DW-1:0]            i_data,
    input  logic                     i_pop,
    output logic [AW-1:0]            o_head_addr,
    output logic [DW-1:0]            o_head_data,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [AW+DW-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q,  level_d;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_full    = (level_q == LVL_W'(DEPTH));
    assign o_empty   = (level_q == '0);
    assign o_level   = level_q;
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop  && !o_empty;

    assign {o_head_addr, o_head_data} = mem_q[rd_ptr_q];

    // Pointers wrap naturally because DEPTH is a power of 2.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (w_push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (w_pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({w_push_ok, w_pop_ok})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: entries are only visible once the level says so.
    always_ff @(posedge clk) begin
        if (w_push_ok) mem_q[wr_ptr_q] <= {i_addr, i_data};
    end

endmodule
`default_nettype wire

// File: rtl/vram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : vram_port_arbiter
//  Description : Shares video RAM port A between the CPU data path and the
//                camera pixel writer. Camera writes are buffered in a FIFO and
//                drained when the CPU is idle, or forcibly once the FIFO hits
//                its high-water mark or the camera has waited MAX_WAIT cycles.
//  Ports       : clk, reset (async, active-low)
//                cpu_req/we/addr/wdata -> cpu_ready, cpu_rdata, cpu_rvalid
//                cam_valid/addr/data   -> cam_full, cam_drop_cnt
//                ram_address/data/wren -> RAM port A, ram_q <- RAM q_a
//  Revision    : 1.0 - initial release
// ============================================================================
module vram_port_arbiter
    import vram_arb_pkg::*;
#(
    parameter int ADDR_W     = C_ADDR_W,
    parameter int DATA_W     = C_DATA_W,
    parameter int FIFO_DEPTH = C_FIFO_DEPTH,
    parameter int HIGH_WATER = C_HIGH_WATER,
    parameter int LOW_WATER  = C_LOW_WATER,
    parameter int MAX_WAIT   = C_MAX_WAIT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ready,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid,
    input  logic              cam_valid,
    input  logic [ADDR_W-1:0] cam_addr,
    input  logic [DATA_W-1:0] cam_data,
    output logic              cam_full,
    output logic [15:0]       cam_drop_cnt,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q
);

    localparam int LVL_W    = $clog2(FIFO_DEPTH) + 1;
    localparam int STARVE_W = $clog2(MAX_WAIT + 1);

    arb_mode_e           mode_q, mode_d;
    arb_grant_e          w_grant;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic                rvalid_q, rvalid_d;
    logic [15:0]         drop_q, drop_d;
    logic [ADDR_W-1:0]   addr_hold_q, addr_hold_d;
    logic [DATA_W-1:0]   data_hold_q, data_hold_d;

    logic [ADDR_W-1:0]   w_head_addr;
    logic [DATA_W-1:0]   w_head_data;
    logic [LVL_W-1:0]    w_level;
    logic [LVL_W-1:0]    w_level_nxt;
    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_pop;

    // Drop decision uses the registered full flag, so a same-cycle pop does
    // not make room for an incoming pixel.
    assign w_push = cam_valid && !w_full;
    assign w_pop  = (w_grant == GNT_CAM);

    vram_wr_fifo #(
        .AW    (ADDR_W),
        .DW    (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_push),
        .i_addr      (cam_addr),
        .i_data      (cam_data),
        .i_pop       (w_pop),
        .o_head_addr (w_head_addr),
        .o_head_data (w_head_data),
        .o_level     (w_level),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    // Occupancy after this cycle's push/pop; drain exit looks at this.
    assign w_level_nxt = w_level + LVL_W'(w_push) - LVL_W'(w_pop);

    // Grant from registered state. Held off entirely while reset is asserted
    // so the RAM port stays quiet.
    always_comb begin
        w_grant = GNT_NONE;
        if (reset) begin
            if (mode_q == CPU_PRIO) begin
                if (cpu_req)       w_grant = GNT_CPU;
                else if (!w_empty) w_grant = GNT_CAM;
            end else if (!w_empty) begin
                w_grant = GNT_CAM;
            end
        end
    end

    // Port A mux; without a grant the bus parks on its last driven value.
    always_comb begin
        cpu_ready   = 1'b0;
        ram_wren    = 1'b0;
        ram_address = addr_hold_q;
        ram_data    = data_hold_q;
        case (w_grant)
            GNT_CPU: begin
                cpu_ready   = 1'b1;
                ram_wren    = cpu_we;
                ram_address = cpu_addr;
                ram_data    = cpu_wdata;
            end
            GNT_CAM: begin
                ram_wren    = 1'b1;
                ram_address = w_head_addr;
                ram_data    = w_head_data;
            end
            default: ;
        endcase
        addr_hold_d = ram_address;
        data_hold_d = ram_data;
    end

    // Mode FSM.
    always_comb begin
        mode_d = mode_q;
        case (mode_q)
            CPU_PRIO: begin
                if ((32'(w_level) >= HIGH_WATER) || (32'(starve_q) == MAX_WAIT))
                    mode_d = CAM_DRAIN;
            end
            CAM_DRAIN: begin
                if (32'(w_level_nxt) <= LOW_WATER)
                    mode_d = CPU_PRIO;
            end
            default: mode_d = CPU_PRIO;
        endcase
    end

    // Starve counter, read-valid pipeline and saturating drop counter.
    always_comb begin
        starve_d = starve_q;
        if (w_empty || (w_grant == GNT_CAM))
            starve_d = '0;
        else if (32'(starve_q) < MAX_WAIT)
            starve_d = starve_q + STARVE_W'(1);

        rvalid_d = (w_grant == GNT_CPU) && !cpu_we;

        drop_d = drop_q;
        if (cam_valid && w_full && (drop_q != 16'hFFFF))
            drop_d = drop_q + 16'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_q      <= CPU_PRIO;
            starve_q    <= '0;
            rvalid_q    <= 1'b0;
            drop_q      <= '0;
            addr_hold_q <= '0;
            data_hold_q <= '0;
        end else begin
            mode_q      <= mode_d;
            starve_q    <= starve_d;
            rvalid_q    <= rvalid_d;
            drop_q      <= drop_d;
            addr_hold_q <= addr_hold_d;
            data_hold_q <= data_hold_d;
        end
    end

    assign cpu_rvalid   = rvalid_q;
    assign cpu_rdata    = ram_q;
    assign cam_full     = w_full;
    assign cam_drop_cnt = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_vram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vram_port_arbiter
//  Description : Directed self-checking bench for vram_port_arbiter. A default
//                instance is attached to a RAM model; a second instance with
//                forcing disabled exercises FIFO overflow.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vram_port_arbiter;

    logic        clk;
    logic        rst_n;
    int          n_tests;
    int          n_fail;

    // Default instance
    logic        cpu_req, cpu_we, cpu_ready, cpu_rvalid;
    logic [15:0] cpu_addr;
    logic [31:0] cpu_wdata, cpu_rdata;
    logic        cam_valid, cam_full;
    logic [15:0] cam_addr, cam_drop_cnt;
    logic [31:0] cam_data;
    logic [15:0] ram_address;
    logic [31:0] ram_data, ram_q;
    logic        ram_wren;

    // Overflow instance
    logic        ov_cpu_req, ov_cpu_we, ov_cpu_ready, ov_cpu_rvalid;
    logic [15:0] ov_cpu_addr;
    logic [31:0] ov_cpu_wdata, ov_cpu_rdata;
    logic        ov_cam_valid, ov_cam_full;
    logic [15:0] ov_cam_addr, ov_cam_drop_cnt;
    logic [31:0] ov_cam_data;
    logic [15:0] ov_ram_address;
    logic [31:0] ov_ram_data, ov_ram_q;
    logic        ov_ram_wren;

    logic [31:0] ram_mem [0:65535];

    vram_port_arbiter u_dut (
        .clk(clk), .reset(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .cam_valid(cam_valid), .cam_addr(cam_addr), .cam_data(cam_data),
        .cam_full(cam_full), .cam_drop_cnt(cam_drop_cnt),
        .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren), .ram_q(ram_q)
    );

    vram_port_arbiter #(.LOW_WATER(0), .HIGH_WATER(9), .MAX_WAIT(255)) u_ovf (
        .clk(clk), .reset(rst_n),
        .cpu_req(ov_cpu_req), .cpu_we(ov_cpu_we), .cpu_addr(ov_cpu_addr), .cpu_wdata(ov_cpu_wdata),
        .cpu_ready(ov_cpu_ready), .cpu_rdata(ov_cpu_rdata), .cpu_rvalid(ov_cpu_rvalid),
        .cam_valid(ov_cam_valid), .cam_addr(ov_cam_addr), .cam_data(ov_cam_data),
        .cam_full(ov_cam_full), .cam_drop_cnt(ov_cam_drop_cnt),
        .ram_address(ov_ram_address), .ram_data(ov_ram_data), .ram_wren(ov_ram_wren), .ram_q(ov_ram_q)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single-port RAM with one-cycle read latency (old data on collision).
    always @(posedge clk) begin
        if (ram_wren) ram_mem[ram_address] <= ram_data;
        ram_q <= ram_mem[ram_address];
    end
    assign ov_ram_q = 32'h0;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        cam_valid = 1'b0; cam_addr = '0; cam_data = '0;
        ov_cpu_req = 1'b0; ov_cpu_we = 1'b0; ov_cpu_addr = '0; ov_cpu_wdata = '0;
        ov_cam_valid = 1'b0; ov_cam_addr = '0; ov_cam_data = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h1234; cpu_wdata = 32'hFFFF_FFFF;
        @(negedge clk);
        n_tests++; if (cpu_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b want 0", cpu_ready); end
        n_tests++; if (ram_wren !== 1'b0) begin n_fail++; $display("FAIL rst_wren: got %b want 0", ram_wren); end
        n_tests++; if (ram_address !== 16'h0) begin n_fail++; $display("FAIL rst_addr: got %h want 0000", ram_address); end
        n_tests++; if (ram_data !== 32'h0) begin n_fail++; $display("FAIL rst_data: got %h want 0", ram_data); end
        n_tests++; if (cpu_rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_rvalid: got %b want 0", cpu_rvalid); end
        n_tests++; if (cam_drop_cnt !== 16'h0) begin n_fail++; $display("FAIL rst_drop: got %h want 0", cam_drop_cnt); end
        n_tests++; if (cam_full !== 1'b0) begin n_fail++; $display("FAIL rst_full: got %b want 0", cam_full); end
        cycle();
        idle_inputs();
        rst_n = 1'b1;
        cycle();
    endtask

    task automatic test_cpu_wr_rd();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0010; cpu_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        n_tests++; if (cpu_ready !== 1'b1) begin n_fail++; $display("FAIL t1_wr_ready: got %b want 1", cpu_ready); end
        n_tests++; if (ram_wren !== 1'b1 || ram_address !== 16'h0010 || ram_data !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL t1_wr_bus: got we=%b a=%h d=%h want 1/0010/deadbeef", ram_wren, ram_address, ram_data); end
        cycle();
        cpu_we = 1'b0; cpu_wdata = 32'h0;
        @(negedge clk);
        n_tests++; if (cpu_ready !== 1'b1 || ram_wren !== 1'b0) begin
            n_fail++; $display("FAIL t1_rd_ready: got ready=%b we=%b want 1/0", cpu_ready, ram_wren); end
        n_tests++; if (cpu_rvalid !== 1'b0) begin n_fail++; $display("FAIL t1_wr_no_rvalid: got %b want 0", cpu_rvalid); end
        cycle();
        cpu_req = 1'b0;
        @(negedge clk);
        n_tests++; if (cpu_rvalid !== 1'b1) begin n_fail++; $display("FAIL t1_rvalid: got %b want 1", cpu_rvalid); end
        n_tests++; if (cpu_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL t1_rdata: got %h want deadbeef", cpu_rdata); end
        cycle();
        @(negedge clk);
        n_tests++; if (cpu_rvalid !== 1'b0) begin n_fail++; $display("FAIL t1_rvalid_once: got %b want 0", cpu_rvalid); end
        cycle();
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals [2];
        vals[0] = 32'h1111_AAAA; vals[1] = 32'h2222_BBBB;
        for (int i = 0; i < 2; i++) begin
            cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0020 + 16'(i); cpu_wdata = vals[i];
            cycle();
        end
        for (int i = 0; i < 2; i++) begin
            cpu_we = 1'b0; cpu_addr = 16'h0020 + 16'(i);
            @(negedge clk);
            if (i == 1) begin
                n_tests++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== vals[0]) begin
                    n_fail++; $display("FAIL b2b_rd0: got v=%b d=%h want 1/%h", cpu_rvalid, cpu_rdata, vals[0]); end
            end
            cycle();
        end
        cpu_req = 1'b0;
        @(negedge clk);
        n_tests++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== vals[1]) begin
            n_fail++; $display("FAIL b2b_rd1: got v=%b d=%h want 1/%h", cpu_rvalid, cpu_rdata, vals[1]); end
        cycle();
        @(negedge clk);
        n_tests++; if (cpu_rvalid !== 1'b0) begin n_fail++; $display("FAIL b2b_end: got %b want 0", cpu_rvalid); end
        cycle();
    endtask

    task automatic test_cam_idle();
        for (int c = 0; c < 5; c++) begin
            cam_valid = (c < 3);
            cam_addr  = 16'h0100 + 16'(c);
            cam_data  = 32'hC000_0000 + 32'(c);
            @(negedge clk);
            if (c == 0 || c == 4) begin
                n_tests++; if (ram_wren !== 1'b0) begin n_fail++; $display("FAIL t2_idle_c%0d: got wren %b want 0", c, ram_wren); end
            end else begin
                n_tests++; if (ram_wren !== 1'b1 || ram_address !== 16'h0100 + 16'(c - 1) || ram_data !== 32'hC000_0000 + 32'(c - 1)) begin
                    n_fail++; $display("FAIL t2_write_c%0d: got we=%b a=%h d=%h want 1/%h/%h", c, ram_wren, ram_address, ram_data,
                                       16'h0100 + 16'(c - 1), 32'hC000_0000 + 32'(c - 1)); end
            end
            cycle();
        end
        @(negedge clk);
        n_tests++; if (ram_address !== 16'h0102) begin n_fail++; $display("FAIL t2_addr_hold: got %h want 0102", ram_address); end
        n_tests++; if (cam_drop_cnt !== 16'h0 || cam_full !== 1'b0) begin
            n_fail++; $display("FAIL t2_status: got drop=%h full=%b want 0/0", cam_drop_cnt, cam_full); end
        cycle();
    endtask

    task automatic test_high_water();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0000;
        for (int c = 0; c < 15; c++) begin
            cam_valid = (c < 6);
            cam_addr  = 16'h0200 + 16'(c);
            cam_data  = 32'hA0 + 32'(c);
            if (c >= 12) cpu_req = 1'b0;
            @(negedge clk);
            if (c <= 6 || c == 11) begin
                n_tests++; if (cpu_ready !== 1'b1 || ram_wren !== 1'b0) begin
                    n_fail++; $display("FAIL t3_cpu_c%0d: got ready=%b we=%b want 1/0", c, cpu_ready, ram_wren); end
            end else if (c <= 10) begin
                n_tests++; if (cpu_ready !== 1'b0 || ram_wren !== 1'b1 || ram_address !== 16'h0200 + 16'(c - 7)) begin
                    n_fail++; $display("FAIL t3_drain_c%0d: got ready=%b we=%b a=%h want 0/1/%h", c, cpu_ready, ram_wren,
                                       ram_address, 16'h0200 + 16'(c - 7)); end
            end else if (c <= 13) begin
                n_tests++; if (ram_wren !== 1'b1 || ram_address !== 16'h0200 + 16'(c - 8) || ram_data !== 32'hA0 + 32'(c - 8)) begin
                    n_fail++; $display("FAIL t3_tail_c%0d: got we=%b a=%h d=%h want 1/%h/%h", c, ram_wren, ram_address, ram_data,
                                       16'h0200 + 16'(c - 8), 32'hA0 + 32'(c - 8)); end
            end else begin
                n_tests++; if (ram_wren !== 1'b0) begin n_fail++; $display("FAIL t3_empty: got wren %b want 0", ram_wren); end
            end
            cycle();
        end
    endtask

    task automatic test_starvation();
        int found;
        found = -1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0000;
        cam_valid = 1'b1; cam_addr = 16'h0300; cam_data = 32'h5A5A_1234;
        cycle();
        cam_valid = 1'b0;
        for (int k = 0; k < 40 && found < 0; k++) begin
            @(negedge clk);
            if (ram_wren === 1'b1 && cpu_ready === 1'b0) begin
                found = k;
                n_tests++; if (ram_address !== 16'h0300 || ram_data !== 32'h5A5A_1234) begin
                    n_fail++; $display("FAIL t4_pixel: got a=%h d=%h want 0300/5a5a1234", ram_address, ram_data); end
            end
            cycle();
        end
        n_tests++; if (found != 17) begin n_fail++; $display("FAIL t4_latency: got %0d want 17 (-1 = timeout)", found); end
        cpu_req = 1'b0;
        cycle();
    endtask

    task automatic test_overflow();
        ov_cpu_req = 1'b1; ov_cpu_we = 1'b0; ov_cpu_addr = 16'h0000;
        for (int c = 0; c < 10; c++) begin
            ov_cam_valid = 1'b1; ov_cam_addr = 16'h0400 + 16'(c); ov_cam_data = 32'hB000_0000 + 32'(c);
            @(negedge clk);
            n_tests++; if (ov_cam_full !== (c >= 8)) begin
                n_fail++; $display("FAIL t5_full_c%0d: got %b want %b", c, ov_cam_full, (c >= 8)); end
            cycle();
        end
        ov_cam_valid = 1'b0;
        @(negedge clk);
        n_tests++; if (ov_cam_drop_cnt !== 16'd2) begin n_fail++; $display("FAIL t5_drop: got %0d want 2", ov_cam_drop_cnt); end
        n_tests++; if (ov_cpu_ready !== 1'b1 || ov_ram_wren !== 1'b0) begin
            n_fail++; $display("FAIL t5_cpu_hold: got ready=%b we=%b want 1/0", ov_cpu_ready, ov_ram_wren); end
        cycle();
        ov_cpu_req = 1'b0;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            if (k < 8) begin
                n_tests++; if (ov_ram_wren !== 1'b1 || ov_ram_address !== 16'h0400 + 16'(k) || ov_ram_data !== 32'hB000_0000 + 32'(k)) begin
                    n_fail++; $display("FAIL t5_order_%0d: got we=%b a=%h d=%h want 1/%h/%h", k, ov_ram_wren, ov_ram_address,
                                       ov_ram_data, 16'h0400 + 16'(k), 32'hB000_0000 + 32'(k)); end
            end else begin
                n_tests++; if (ov_ram_wren !== 1'b0 || ov_cam_full !== 1'b0) begin
                    n_fail++; $display("FAIL t5_drained: got we=%b full=%b want 0/0", ov_ram_wren, ov_cam_full); end
            end
            cycle();
        end
    endtask

    task automatic test_reset_mid();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
        cam_valid = 1'b1; cam_addr = 16'h0500; cam_data = 32'h7777_0000;
        cycle();
        cam_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        n_tests++; if (cpu_rvalid !== 1'b0) begin n_fail++; $display("FAIL t6_rvalid: got %b want 0", cpu_rvalid); end
        n_tests++; if (cpu_ready !== 1'b0 || ram_wren !== 1'b0 || ram_address !== 16'h0) begin
            n_fail++; $display("FAIL t6_port: got ready=%b we=%b a=%h want 0/0/0000", cpu_ready, ram_wren, ram_address); end
        n_tests++; if (cam_drop_cnt !== 16'h0) begin n_fail++; $display("FAIL t6_drop: got %h want 0", cam_drop_cnt); end
        cycle();
        rst_n = 1'b1;
        cpu_req = 1'b0;
        @(negedge clk);
        n_tests++; if (ram_wren !== 1'b0 || cpu_rvalid !== 1'b0) begin
            n_fail++; $display("FAIL t6_fifo_empty: got we=%b rvalid=%b want 0/0", ram_wren, cpu_rvalid); end
        cycle();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0030; cpu_wdata = 32'h0BAD_CAFE;
        cycle();
        cpu_we = 1'b0;
        cycle();
        cpu_req = 1'b0;
        @(negedge clk);
        n_tests++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'h0BAD_CAFE) begin
            n_fail++; $display("FAIL t6_after: got v=%b d=%h want 1/0badcafe", cpu_rvalid, cpu_rdata); end
        cycle();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        idle_inputs();
        test_reset();
        test_cpu_wr_rd();
        test_back_to_back();
        test_cam_idle();
        test_high_water();
        test_starvation();
        test_overflow();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vram_port_arbiter.md
Name: vram_port_arbiter

Overview:
- Shares the single read/write port A of the video RAM (ram_2port) between two requesters: the ARM core's data-memory path, and the camera pixel writer.
- Camera writes land in a small internal FIFO and are drained into RAM when the CPU does not need the port, or forcibly when the FIFO fills or the camera is starved.
- Sits between the arm core / camera capture logic and RAM_VIDEO port A.

Parameters:
- ADDR_W, 16, RAM word-address width
- DATA_W, 32, data width
- FIFO_DEPTH, 8, camera write FIFO entries; power of 2, minimum 4
- HIGH_WATER, 6, FIFO level that forces drain mode
- LOW_WATER, 2, FIFO level at or below which drain mode exits
- MAX_WAIT, 16, consecutive ungranted cycles with FIFO non-empty that force drain mode

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- cpu_req  in  1  CPU access request
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU word address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_ready  out  1  CPU access granted this cycle
- cpu_rdata  out  DATA_W  read data, valid only when cpu_rvalid = 1
- cpu_rvalid  out  1  read data valid
- cam_valid  in  1  camera pixel write strobe (no backpressure)
- cam_addr  in  ADDR_W  pixel word address
- cam_data  in  DATA_W  pixel data
- cam_full  out  1  FIFO full
- cam_drop_cnt  out  16  saturating count of dropped pixels
- ram_address  out  ADDR_W  to RAM address_a
- ram_data  out  DATA_W  to RAM data_a
- ram_wren  out  1  to RAM wren_a
- ram_q  in  DATA_W  from RAM q_a (1-cycle read latency)

Behaviour:
- Reset (reset = 0, asynchronous):
  - FIFO emptied; mode = CPU_PRIO; starve counter = 0; cam_drop_cnt = 0; cpu_rvalid = 0.
  - While reset is low: cpu_ready = 0, ram_wren = 0, ram_address = 0, ram_data = 0.
- Grant is combinational from the current registered state; at most one access per cycle.
- Mode FSM:
  - CPU_PRIO:
    - cpu_req = 1: grant CPU.
    - Otherwise, if FIFO non-empty: grant camera (pop head).
    - Go to CAM_DRAIN when level >= HIGH_WATER, or starve counter == MAX_WAIT. Evaluated on registered values; effective next cycle.
  - CAM_DRAIN:
    - Grant camera whenever FIFO non-empty; cpu_ready = 0.
    - Return to CPU_PRIO when level <= LOW_WATER, evaluated after this cycle's push/pop.
- Starve counter:
  - Increments each cycle the FIFO is non-empty and the camera is not granted.
  - Clears on a camera grant or when the FIFO is empty.
  - Saturates at MAX_WAIT.
- CPU grant:
  - cpu_ready = 1.
  - ram_address = cpu_addr; ram_wren = cpu_we; ram_data = cpu_wdata.
- Camera grant:
  - ram_address / ram_data = FIFO head; ram_wren = 1; FIFO pops.
- No grant: ram_wren = 0; address and data hold their last driven values.
- Reads:
  - A granted CPU read sets cpu_rvalid = 1 on the next cycle, for exactly 1 cycle.
  - cpu_rdata = ram_q in that cycle.
  - Back-to-back reads give rvalid on consecutive cycles.
  - CPU writes never raise rvalid.
- FIFO push:
  - cam_valid = 1 and not full: push.
  - cam_valid = 1 and full (registered full, before a same-cycle pop): pixel dropped; cam_drop_cnt += 1, saturating at 0xFFFF.
  - Push and pop in the same cycle: level unchanged.
  - Pointers wrap modulo FIFO_DEPTH; level counter is log2(FIFO_DEPTH)+1 bits wide.
- Pixel ordering: pixels are written to RAM in arrival order, never reordered.
- Reset mid-operation: pending rvalid is cancelled; FIFO contents are discarded.

Decomposition:
- Shared package vram_arb_pkg:
  - mode enum {CPU_PRIO, CAM_DRAIN}.
  - grant enum {GNT_NONE, GNT_CPU, GNT_CAM}.
  - Default parameter constants.
- Sub-module vram_wr_fifo:
  - Synchronous FIFO of {addr, data}.
  - Outputs level, full and empty.
  - Same clk / active-low async reset.
- Arbiter FSM, starve counter, read-valid pipeline and drop counter stay in vram_port_arbiter.

Test Plan:
1. CPU write then read, FIFO empty:
   - Stimulus: write addr 0x0010 data 0xDEADBEEF; next cycle read 0x0010.
   - Required: cpu_ready = 1 both cycles; cpu_rvalid = 1 one cycle after the read with cpu_rdata = 0xDEADBEEF.
2. Idle CPU, camera traffic:
   - Stimulus: push 3 pixels at 0x0100..0x0102.
   - Required: each written one cycle after push (ram_wren = 1); level returns to 0; cam_drop_cnt = 0.
3. High-water forcing:
   - Stimulus: cpu_req held high continuously; push 6 pixels.
   - Required: mode enters CAM_DRAIN; cpu_ready = 0 while the FIFO drains to level 2; CPU regrant on the following cycle.
4. Starvation:
   - Stimulus: cpu_req held high; push 1 pixel.
   - Required: camera granted 17 cycles after the push (MAX_WAIT = 16 plus transition); pixel written intact.
5. Overflow:
   - Stimulus: cpu_req high with starve/high-water disabled via LOW_WATER = 0, HIGH_WATER = 9, MAX_WAIT = 255 instance; push 10 pixels.
   - Required: cam_full = 1 after 8 pushes; cam_drop_cnt = 2; first 8 pixels drain in order.
6. Reset mid-read:
   - Stimulus: assert reset in the cycle after a granted read.
   - Required: cpu_rvalid = 0 immediately; FIFO empty; cam_drop_cnt = 0; normal operation after release.
